// File: rtl/route_distance.sv
// route_distance: closed-tour length of a stream of city indices.
// Each tour is CITY_NUM beats. Consecutive pairs, plus the wrap from the
// last city back to the first, are looked up in a host-loaded distance
// table and summed. The total is reported as a one-cycle out_valid pulse.
// Optional build macro: ROUTE_DIST_CHECK_EN adds a per-tour permutation
// check (duplicates / out-of-range indices) reported on out_error.
module route_distance #(
   parameter int CITY_NUM = 30,
   parameter int CITY_W   = $clog2(CITY_NUM),
   parameter int DIST_W   = 16,
   parameter int SUM_W    = DIST_W + $clog2(CITY_NUM)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [CITY_W-1:0]     in_data,
   input  logic                  dist_we,
   input  logic [2*CITY_W-1:0]   dist_waddr,
   input  logic [DIST_W-1:0]     dist_wdata,
   output logic                  out_valid,
   output logic [SUM_W-1:0]      out_total,
   output logic                  out_error
);

   localparam int DEPTH = 1 << (2 * CITY_W);
   localparam logic [CITY_W-1:0] LAST_BEAT   = CITY_W'(CITY_NUM - 1);
   localparam logic [CITY_W-1:0] SECOND_BEAT = CITY_W'(1);

   logic [CITY_W-1:0]   bcnt;
   logic [CITY_W-1:0]   first_city;
   logic [CITY_W-1:0]   prev_city;
   logic                close_pend;
   logic                beat_first;
   logic                beat_last;
   logic                rd_en;
   logic [2*CITY_W-1:0] rd_addr;
   logic [DIST_W-1:0]   mem [DEPTH];
   logic [DIST_W-1:0]   ram_q;
   logic                s1_vld;
   logic                s1_load;
   logic                s1_close;
   logic                s2_done;
   logic [SUM_W-1:0]    acc;

   assign beat_first = in_valid && (bcnt == '0);
   assign beat_last  = in_valid && (bcnt == LAST_BEAT);

   // Read port arbitration: the closing lookup always lands on the cycle
   // after the last beat, which is either idle or a first beat (no lookup).
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = {prev_city, in_data};
      if (close_pend) begin
         rd_en   = 1'b1;
         rd_addr = {prev_city, first_city};
      end else if (in_valid && !beat_first) begin
         rd_en = 1'b1;
      end
   end

   // Distance table: one write port, one synchronous read port, read-old-data.
   always_ff @(posedge clk) begin
      if (dist_we) mem[dist_waddr] <= dist_wdata;
      if (rd_en)   ram_q <= mem[rd_addr];
   end

   // Beat counter and the first/previous city registers of the current tour.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcnt       <= '0;
         first_city <= '0;
         prev_city  <= '0;
         close_pend <= 1'b0;
      end else begin
         close_pend <= beat_last;
         if (in_valid) begin
            bcnt      <= beat_last ? '0 : bcnt + 1'b1;
            prev_city <= in_data;
            if (beat_first) first_city <= in_data;
         end
      end
   end

   // Lookup -> read -> accumulate pipeline. The first pair of a tour loads
   // the accumulator, so a new tour can start while the old total drains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld    <= 1'b0;
         s1_load   <= 1'b0;
         s1_close  <= 1'b0;
         s2_done   <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_total <= '0;
      end else begin
         s1_vld   <= rd_en;
         s1_load  <= !close_pend && in_valid && (bcnt == SECOND_BEAT);
         s1_close <= close_pend;
         s2_done  <= s1_vld && s1_close;
         if (s1_vld) acc <= s1_load ? SUM_W'(ram_q) : acc + SUM_W'(ram_q);
         out_valid <= s2_done;
         if (s2_done) out_total <= acc;
      end
   end

`ifdef ROUTE_DIST_CHECK_EN
   localparam logic [CITY_NUM-1:0] ONE_CITY = CITY_NUM'(1);

   logic [CITY_NUM-1:0] visited;
   logic [CITY_NUM-1:0] city_bit;
   logic                beat_err;
   logic                tour_err;
   logic                err_last;
   logic                s1_err;
   logic                s2_err;

   assign city_bit = ONE_CITY << in_data;
   assign beat_err = ({1'b0, in_data} >= (CITY_W+1)'(CITY_NUM)) ||
                     (!beat_first && (|(visited & city_bit)));

   // Visited bitmap and sticky tour error, carried alongside the sum pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         visited   <= '0;
         tour_err  <= 1'b0;
         err_last  <= 1'b0;
         s1_err    <= 1'b0;
         s2_err    <= 1'b0;
         out_error <= 1'b0;
      end else begin
         if (in_valid) begin
            visited  <= beat_first ? city_bit : (visited | city_bit);
            tour_err <= beat_first ? beat_err : (tour_err | beat_err);
         end
         if (beat_last) err_last <= tour_err | beat_err;
         s1_err <= err_last;
         s2_err <= s1_err;
         if (s2_done) out_error <= s2_err;
      end
   end
`else
   assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_route_distance.sv
// Bench for route_distance with CITY_NUM=8. Expected totals come from a
// plain distance matrix and the tour list; expected error from counting
// repeated cities (only when ROUTE_DIST_CHECK_EN is defined).
module tb_route_distance;

   localparam int N  = 8;
   localparam int CW = 3;
   localparam int DW = 16;
   localparam int SW = 19;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [CW-1:0]   in_data = '0;
   logic            dist_we = 1'b0;
   logic [2*CW-1:0] dist_waddr = '0;
   logic [DW-1:0]   dist_wdata = '0;
   logic            out_valid;
   logic [SW-1:0]   out_total;
   logic            out_error;

   route_distance #(.CITY_NUM(N)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .dist_we(dist_we), .dist_waddr(dist_waddr), .dist_wdata(dist_wdata),
      .out_valid(out_valid), .out_total(out_total), .out_error(out_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            p_cyc[$];
   logic [SW-1:0] p_tot[$];
   logic          p_err[$];
   int            e_cyc[$];
   int            e_tot[$];
   logic          e_err[$];

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         p_cyc.push_back(cyc);
         p_tot.push_back(out_total);
         p_err.push_back(out_error);
      end
   end

   int dtab[N][N];
   int route[N];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_table(input int mode);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int v;
            if (mode == 0)      v = (i > j) ? i - j : j - i;
            else if (mode == 1) v = 16'hFFFF;
            else                v = $urandom_range(0, 16'hFFFF);
            dtab[i][j] = v;
            dist_we    = 1'b1;
            dist_waddr = 6'(i * N + j);
            dist_wdata = 16'(v);
            @(posedge clk); #1;
         end
      end
      dist_we = 1'b0;
   endtask

   task automatic drive_beat(input int city, input int maxgap);
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (g > 0) begin
         in_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = 3'(city);
      @(posedge clk); #1;
   endtask

   task automatic drive_tour(input int maxgap);
      int   sum;
      int   seen[N];
      logic dup;
      sum = 0;
      dup = 1'b0;
      for (int i = 0; i < N; i++) seen[i] = 0;
      for (int i = 0; i < N; i++) begin
         sum += dtab[route[i]][route[(i + 1) % N]];
         if (seen[route[i]] != 0) dup = 1'b1;
         seen[route[i]]++;
      end
      for (int i = 0; i < N; i++) drive_beat(route[i], maxgap);
      e_cyc.push_back(cyc);
      e_tot.push_back(sum);
`ifdef ROUTE_DIST_CHECK_EN
      e_err.push_back(dup);
`else
      e_err.push_back(1'b0);
`endif
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic compare(input string tag);
      idle(8);
      chk({tag, "_count"}, p_tot.size(), e_tot.size());
      for (int i = 0; i < e_tot.size() && i < p_tot.size(); i++) begin
         chk({tag, "_total"},   p_tot[i], e_tot[i]);
         chk({tag, "_error"},   p_err[i], e_err[i]);
         chk({tag, "_latency"}, p_cyc[i] - e_cyc[i], 3);
      end
   endtask

   task automatic clear_q();
      p_cyc.delete(); p_tot.delete(); p_err.delete();
      e_cyc.delete(); e_tot.delete(); e_err.delete();
   endtask

   task automatic shuffle();
      for (int i = 0; i < N; i++) route[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = route[i]; route[i] = route[j]; route[j] = t;
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_total", out_total, 0);
      chk("rst_error", out_error, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // |i-j| table, contiguous route
      load_table(0);
      for (int i = 0; i < N; i++) route[i] = i;
      drive_tour(0);
      compare("contig");
      chk("contig_const", p_tot.size() > 0 ? p_tot[0] : 'x, 14);
      chk("hold_total", out_total, 14);
      clear_q();

      // Interleaved route with random gaps
      route = '{0, 2, 4, 6, 7, 5, 3, 1};
      drive_tour(3);
      compare("gaps");
      clear_q();

      // Back-to-back tours, no idle cycle
      for (int i = 0; i < N; i++) route[i] = i;
      drive_tour(0);
      for (int i = 0; i < N; i++) route[i] = N - 1 - i;
      drive_tour(0);
      compare("b2b");
      if (p_cyc.size() == 2) chk("b2b_spacing", p_cyc[1] - p_cyc[0], 8);
      else                   chk("b2b_pulses", p_cyc.size(), 2);
      clear_q();

      // Random table, random permutations, mixed gaps / back-to-back
      load_table(2);
      for (int t = 0; t < 6; t++) begin
         shuffle();
         drive_tour((t % 2) * 2);
      end
      compare("rand");
      clear_q();

      // Saturated table: no truncation of the total
      load_table(1);
      shuffle();
      drive_tour(1);
      compare("maxval");
      chk("maxval_const", p_tot.size() > 0 ? p_tot[0] : 'x, 19'h7FFF8);
      clear_q();

      // Duplicate city followed by a clean tour (error must not carry over)
      load_table(0);
      route = '{0, 1, 1, 3, 4, 5, 6, 7};
      drive_tour(0);
      for (int i = 0; i < N; i++) route[i] = i;
      drive_tour(0);
      compare("dup");
      clear_q();

      // Random indices, duplicates likely
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) route[i] = $urandom_range(0, N - 1);
         drive_tour(1);
      end
      compare("randidx");
      clear_q();

      // Reset after beat 4 discards the partial tour
      for (int i = 0; i < 5; i++) drive_beat(i, 0);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_total", out_total, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) route[i] = i;
      drive_tour(0);
      compare("midrst");
      clear_q();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/route_distance.md
# route_distance

Downstream consumer of the replica route RAM's output stream. Each tour arrives as CITY_NUM city indices, one per valid beat. The block looks up the distance between each consecutive pair, including the wrap from the last city back to the first, in an internal distance table, and reports the closed-tour total as a single-cycle result pulse. The block feeds the replica energy/exchange decision logic and has no backpressure, matching its upstream source.

## Interface
- CITY_NUM, 30: cities per tour; must be ≥ 2; equals city_num of the route RAM.
- CITY_W, $clog2(CITY_NUM): city index width.
- DIST_W, 16: width of one distance entry.
- SUM_W, DIST_W+$clog2(CITY_NUM): total width; cannot overflow.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  city beat valid.
- in_data  in  CITY_W  city index.
- dist_we  in  1  distance table write strobe.
- dist_waddr  in  2*CITY_W  write address {from, to}.
- dist_wdata  in  DIST_W  distance value.
- out_valid  out  1  one-cycle pulse: total valid.
- out_total  out  SUM_W  closed-tour length.
- out_error  out  1  permutation check failed; valid with out_valid.

## Operation
- Distance table: 2^(2*CITY_W) x DIST_W RAM with 1 write port and 1 synchronous read port.
  - Read address is {from, to}.
  - The table is not reset.
  - A same-address read and write in the same cycle returns the old data.
  - The host loads the table before the first tour. Writes during a tour are permitted; the affected total is then undefined.
- Beat counter `bcnt` (0..CITY_NUM-1) advances on every in_valid and wraps to 0 after CITY_NUM-1.
  - Gaps (in_valid low) are allowed anywhere and freeze all state.
- At bcnt==0: latch the city into `first` and `prev`. No lookup is issued and the accumulator is cleared.
- At bcnt==k (k ≥ 1): issue a lookup of {prev, in_data}, then set prev ← in_data.
- After the beat with bcnt==CITY_NUM-1: on the next cycle, issue a closing lookup {in_data_last, first}, unconditionally.
  - That cycle may carry the next tour's first beat, which needs no lookup, so there is no port conflict.
  - The next tour uses its own `first` and `prev` registers, fed through a pipeline tag, so back-to-back tours are supported.
- Read data is added into the accumulator one cycle after its lookup.
- After the closing addition:
  - out_total ← accumulator sum, out_valid ← 1 for one cycle.
  - The accumulator is then free for the next tour.
- No state machine beyond bcnt plus a 2-stage valid/last/tag pipeline: lookup → read → accumulate.
- All distances are unsigned; the sum is zero-extended.

## Timing
- Reset values: out_valid=0, out_total=0, out_error=0, bcnt=0; the accumulator and the pipeline valids are cleared.
- Reset mid-tour discards the partial tour. The first beat after release is treated as bcnt==0.
- Latency: if the last beat is sampled at edge E, out_valid is high in the cycle following edge E+3.
- Throughput: one tour per CITY_NUM beats with zero idle cycles between tours.
- out_total and out_error hold their value until the next out_valid.

## Configuration
- ROUTE_DIST_CHECK_EN defined: a CITY_NUM-bit visited bitmap is cleared at bcnt==0. Each beat sets its bit.
  - A duplicate, or an index ≥ CITY_NUM, sets a sticky tour-error flag.
  - The flag is presented on out_error with out_valid; the total is still reported.
- ROUTE_DIST_CHECK_EN undefined: the bitmap is not built and out_error is tied to 0.

## Test plan
- CITY_NUM=8, table d(i,j)=|i-j|, route 0..7 contiguous → out_total=14, out_error=0, 3 cycles after the last beat.
- Same table, route 0,2,4,6,7,5,3,1 with random 0-3 cycle gaps → out_total=14.
- Two tours back-to-back (0..7 then 7..0), no idle cycle → two pulses 8 cycles apart, both out_total=14.
- All entries 0xFFFF, any valid route → out_total=8*0xFFFF=0x7FFF8 with no truncation.
- Duplicate city (0,1,1,3,4,5,6,7), ROUTE_DIST_CHECK_EN on → out_error=1; with it off → out_error=0.
- Assert reset_n low after beat 4, then feed route 0..7 → exactly one pulse, out_total=14.
